hsst_fifo_rd_checker: RTL and testbench
=======================================

Name: hsst_fifo_rd_checker

Overview:
Read-side consumer and self-checker for the hsst_fifo asynchronous FIFO. It pairs with the write-side stimulus, which loads a descending counter pattern starting at all-ones. On start, the block drains a burst of words from the FIFO read port, honouring rd_empty. It compares each returned word against the expected descending sequence, taking the configured read latency into account, and reports error count, done and pass. It is instantiated in the hsst_fifo benches and in the on-board loopback self-test.

Parameters:
DATA_WIDTH, 16, width of rd_data and of the expected-data counter.
RD_LATENCY, 1, cycles from rd_en to valid rd_data. Legal values: 1 (OUTPUT_REG=0) or 2 (OUTPUT_REG=1).
BURST_LEN, 2048, number of words read and compared per run (range 1..65535).
SEED, {DATA_WIDTH{1'b1}}, first expected word after start.
ERR_W, 3, width of the saturating error counter.

Ports:
clk  in  1  single clock shared by the FIFO read side and the checker.
tb_rst  in  1  reset, asynchronous, active-high.
start  in  1  one-cycle pulse that begins a run; ignored while busy.
rd_empty  in  1  FIFO empty flag.
rd_data  in  DATA_WIDTH  FIFO read data.
rd_en  out  1  FIFO read enable.
busy  out  1  high from the accepted start until done.
done  out  1  high once all BURST_LEN words have been compared; held until the next start.
pass  out  1  done && (err_cnt == 0).
err_cnt  out  ERR_W  count of mismatches; saturates at all-ones.
rd_count  out  16  number of rd_en pulses issued in the current run.
first_err_data  out  DATA_WIDTH  rd_data of the first mismatch in the run; 0 if there is none.

Behaviour:
- Reset (async assert, release on the next clk edge): state=IDLE; rd_en=0; busy=0; done=0; pass=0; err_cnt=0; rd_count=0; first_err_data=0; expected=SEED; valid pipe cleared.
- States:
  - IDLE: start goes to READ. In the same cycle, clear counters, set expected=SEED, clear done.
  - READ: leave for DRAIN when rd_count reaches BURST_LEN on an issued read.
  - DRAIN: wait until the valid pipe is empty and the compare count reaches BURST_LEN, then go to DONE.
  - DONE: done=1. start goes back to READ with the same clears as in IDLE.
- rd_en is combinational: rd_en = (state==READ) && !rd_empty && (rd_count < BURST_LEN). It never asserts while rd_empty=1, so the FIFO cannot underflow. A stall in READ while the FIFO is empty is legal and has no timeout.
- rd_count increments on every cycle with rd_en=1.
- Valid pipe: a shift register RD_LATENCY deep, fed with rd_en. When the tail is set, rd_data is sampled on that edge and compared with expected.
- Compare:
  - Mismatch: increments err_cnt unless it is already all-ones (saturate, no wrap). On the first mismatch of the run, captures first_err_data.
  - expected decrements by 1 after every compare, modulo 2^DATA_WIDTH. All-zeros wraps to all-ones.
- busy=1 in READ and DRAIN. pass is registered with done.
- start while busy is ignored; the run in progress is unaffected.
- tb_rst mid-run aborts immediately to the reset values. rd_en drops asynchronously with the state.
- almost_empty is not used by this block.

Test Plan:
- Prefill 2048 words FFFF..F800, pulse start with RD_LATENCY=1 -> rd_en high for 2048 consecutive cycles; done asserts 1 cycle after the last compare; err_cnt=0; pass=1; rd_count=2048.
- Same prefill with RD_LATENCY=2 and a 2-cycle data model -> pass=1; done is 1 cycle later than in the RD_LATENCY=1 case.
- Corrupt word index 5 (expected FFFA, return 1234) -> err_cnt=1; first_err_data=1234; pass=0 at done.
- Corrupt 10 words -> err_cnt saturates at 7 (does not wrap); first_err_data holds the first bad value.
- Write side supplies 1 word every 4 cycles -> rd_en never asserts while rd_empty=1; busy stays high; final pass=1.
- BURST_LEN=4, SEED=0001 -> compares 0001, 0000, FFFF, FFFE and passes. tb_rst pulse after the 2nd read -> all outputs return to reset values. Second start pulse during busy -> ignored.

Source files
------------

// File: rtl/hsst_fifo_rd_checker.sv
// hsst_fifo_rd_checker: drains a burst from the FIFO read port and checks it against a descending count
module hsst_fifo_rd_checker #(
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 1,
  parameter int BURST_LEN = 2048,
  parameter logic [DATA_WIDTH-1:0] SEED = {DATA_WIDTH{1'b1}},
  parameter int ERR_W = 3
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic                  start,
  input  logic                  rd_empty,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_en,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_cnt,
  output logic [15:0]           rd_count,
  output logic [DATA_WIDTH-1:0] first_err_data
);
  localparam logic [15:0] BL = 16'(BURST_LEN);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state;
  logic [RD_LATENCY-1:0] vpipe;
  logic [15:0] cmp_count;
  logic [DATA_WIDTH-1:0] expected;
  logic tail, go, mism;
  assign rd_en = (state == READ) && !rd_empty && (rd_count < BL);
  assign busy = (state == READ) || (state == DRAIN);
  assign done = (state == DONE);
  assign tail = vpipe[RD_LATENCY-1];
  assign go = start && !busy;
  assign mism = tail && (rd_data != expected);
  // Run control, read-latency pipe and compare/score state; a start while busy falls through untouched
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state <= IDLE;
      vpipe <= '0;
      rd_count <= '0;
      cmp_count <= '0;
      err_cnt <= '0;
      first_err_data <= '0;
      expected <= SEED;
      pass <= 1'b0;
    end else if (go) begin
      state <= READ;
      vpipe <= '0;
      rd_count <= '0;
      cmp_count <= '0;
      err_cnt <= '0;
      first_err_data <= '0;
      expected <= SEED;
      pass <= 1'b0;
    end else begin
      vpipe <= RD_LATENCY'({vpipe, rd_en});
      if (rd_en) rd_count <= rd_count + 16'd1;
      if (tail) begin
        cmp_count <= cmp_count + 16'd1;
        expected <= expected - DATA_WIDTH'(1);
      end
      if (mism && err_cnt == '0) first_err_data <= rd_data;
      if (mism && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
      if (state == READ && rd_en && rd_count == BL - 16'd1) state <= DRAIN;
      if (state == DRAIN && vpipe == '0 && cmp_count == BL) begin
        state <= DONE;
        pass <= (err_cnt == '0);
      end
    end
  end
endmodule

// File: tb/tb_hsst_fifo_rd_checker.sv
// tb_hsst_fifo_rd_checker: three checker instances fed by behavioural FIFOs, scored per run
module tb_hsst_fifo_rd_checker;
  localparam int N = 3;
  typedef struct {
    logic [2:0]  err;
    logic [15:0] first;
    logic        pass;
    logic [15:0] cnt;
  } res_t;
  logic clk = 1'b0;
  logic tb_rst = 1'b1;
  logic start [N];
  logic rd_empty [N];
  logic rd_en [N];
  logic busy [N];
  logic done [N];
  logic pass [N];
  logic [15:0] rd_data [N];
  logic [15:0] rd_count [N];
  logic [15:0] first_err_data [N];
  logic [2:0] err_cnt [N];
  logic [15:0] mem [N][4096];
  logic [15:0] d1 [N];
  logic [15:0] d2 [N];
  int wp [N] = '{0, 0, 0};
  int rp [N] = '{0, 0, 0};
  int uf [N] = '{0, 0, 0};
  int done_cyc [N] = '{0, 0, 0};
  logic prev_done [N] = '{1'b0, 1'b0, 1'b0};
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  res_t sb [$];
  logic [15:0] words [2048];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < N; k++) begin : g
    localparam int LAT = (k == 1) ? 2 : 1;
    hsst_fifo_rd_checker #(
      .DATA_WIDTH(16), .RD_LATENCY(LAT), .BURST_LEN(k == 2 ? 4 : 2048),
      .SEED(k == 2 ? 16'h0001 : 16'hFFFF), .ERR_W(3)
    ) dut (
      .clk(clk), .tb_rst(tb_rst), .start(start[k]), .rd_empty(rd_empty[k]),
      .rd_data(rd_data[k]), .rd_en(rd_en[k]), .busy(busy[k]), .done(done[k]),
      .pass(pass[k]), .err_cnt(err_cnt[k]), .rd_count(rd_count[k]),
      .first_err_data(first_err_data[k])
    );
    assign rd_empty[k] = (wp[k] == rp[k]);
    assign rd_data[k] = (LAT == 2) ? d2[k] : d1[k];
    always @(posedge clk) begin
      if (rd_en[k]) begin
        d1[k] <= mem[k][rp[k] % 4096];
        rp[k] <= rp[k] + 1;
      end
      d2[k] <= d1[k];
    end
    always @(negedge clk) begin
      if (rd_en[k] && rd_empty[k]) uf[k] = uf[k] + 1;
      if (done[k] && !prev_done[k]) done_cyc[k] = cyc;
      prev_done[k] = done[k];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int k, input logic [15:0] w);
    mem[k][wp[k] % 4096] = w;
    wp[k] = wp[k] + 1;
  endtask

  task automatic pulse(input logic [N-1:0] m, output int s);
    @(negedge clk);
    for (int k = 0; k < N; k++) start[k] = m[k];
    @(negedge clk);
    s = cyc;
    for (int k = 0; k < N; k++) start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k);
    for (int i = 0; i < 20000 && !done[k]; i++) @(negedge clk);
    chk($sformatf("done%0d", k), 32'(done[k]), 1);
    @(negedge clk);
  endtask

  task automatic wait_cnt(input int k, input logic [15:0] n);
    for (int i = 0; i < 50 && rd_count[k] != n; i++) @(negedge clk);
    chk($sformatf("rd_count%0d_reach", k), 32'(rd_count[k]), 32'(n));
  endtask

  function automatic res_t model(input logic [15:0] seed, input int n);
    logic [15:0] e = seed;
    res_t r = '{3'd0, 16'd0, 1'b0, 16'd0};
    r.cnt = 16'(n);
    for (int i = 0; i < n; i++) begin
      if (words[i] !== e) begin
        if (r.err == 3'd0) r.first = words[i];
        if (r.err != 3'd7) r.err = r.err + 3'd1;
      end
      e = e - 16'd1;
    end
    r.pass = (r.err == 3'd0);
    return r;
  endfunction

  task automatic score(input int k);
    res_t r = sb.pop_front();
    chk($sformatf("err_cnt%0d", k), 32'(err_cnt[k]), 32'(r.err));
    chk($sformatf("first_err%0d", k), 32'(first_err_data[k]), 32'(r.first));
    chk($sformatf("pass%0d", k), 32'(pass[k]), 32'(r.pass));
    chk($sformatf("rd_count%0d", k), 32'(rd_count[k]), 32'(r.cnt));
    chk($sformatf("underflow%0d", k), 32'(uf[k]), 0);
    chk($sformatf("busy_at_done%0d", k), 32'(busy[k]), 0);
  endtask

  task automatic chk_reset(input int k);
    chk($sformatf("rst_rd_en%0d", k), 32'(rd_en[k]), 0);
    chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 0);
    chk($sformatf("rst_done%0d", k), 32'(done[k]), 0);
    chk($sformatf("rst_pass%0d", k), 32'(pass[k]), 0);
    chk($sformatf("rst_err%0d", k), 32'(err_cnt[k]), 0);
    chk($sformatf("rst_rd_count%0d", k), 32'(rd_count[k]), 0);
    chk($sformatf("rst_first_err%0d", k), 32'(first_err_data[k]), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int drops;
    for (int k = 0; k < N; k++) start[k] = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) chk_reset(k);
    tb_rst = 1'b0;
    // clean 2048-word burst on both latencies at once
    for (int i = 0; i < 2048; i++) words[i] = 16'hFFFF - 16'(i);
    sb.push_back(model(16'hFFFF, 2048));
    sb.push_back(model(16'hFFFF, 2048));
    for (int i = 0; i < 2048; i++) begin
      put(0, words[i]);
      put(1, words[i]);
    end
    pulse(3'b011, s);
    wait_done(0);
    wait_done(1);
    chk("lat1_done_cycle", 32'(done_cyc[0] - s), 2050);
    chk("lat2_done_cycle", 32'(done_cyc[1] - s), 2051);
    score(0);
    score(1);
    repeat (3) @(negedge clk);
    chk("done_held", 32'(done[0]), 1);
    // single corrupted word at index 5
    words[5] = 16'h1234;
    sb.push_back(model(16'hFFFF, 2048));
    for (int i = 0; i < 2048; i++) put(0, words[i]);
    pulse(3'b001, s);
    wait_done(0);
    score(0);
    // ten corrupted words: counter saturates, first bad value kept
    for (int i = 0; i < 2048; i++) words[i] = 16'hFFFF - 16'(i);
    for (int i = 3; i < 13; i++) words[i] = 16'hA000 + 16'(i);
    sb.push_back(model(16'hFFFF, 2048));
    for (int i = 0; i < 2048; i++) put(0, words[i]);
    pulse(3'b001, s);
    wait_done(0);
    score(0);
    // slow writer: one word every 4 cycles, reader must stall on empty
    for (int i = 0; i < 2048; i++) words[i] = 16'hFFFF - 16'(i);
    sb.push_back(model(16'hFFFF, 2048));
    drops = 0;
    pulse(3'b001, s);
    for (int i = 0; i < 2048; i++) begin
      if (!busy[0]) drops++;
      put(0, words[i]);
      repeat (4) @(negedge clk);
    end
    chk("slow_busy_drops", 32'(drops), 0);
    wait_done(0);
    score(0);
    // short burst across the zero wrap, with a start ignored mid-run
    words[0] = 16'h0001;
    words[1] = 16'h0000;
    words[2] = 16'hFFFF;
    words[3] = 16'hFFFE;
    sb.push_back(model(16'h0001, 4));
    put(2, words[0]);
    put(2, words[1]);
    pulse(3'b100, s);
    wait_cnt(2, 16'd2);
    chk("stall_busy", 32'(busy[2]), 1);
    pulse(3'b100, s);
    put(2, words[2]);
    put(2, words[3]);
    wait_done(2);
    score(2);
    // asynchronous reset after the second read of a run
    for (int i = 0; i < 4; i++) put(2, words[i]);
    pulse(3'b100, s);
    wait_cnt(2, 16'd2);
    #2 tb_rst = 1'b1;
    #1 chk_reset(2);
    @(negedge clk);
    tb_rst = 1'b0;
    wp[2] = rp[2] + 0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy[2]), 0);
    chk("post_rst_done", 32'(done[2]), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
